// File: rtl/edp_diag_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module : edp_diag_reader_pkg
//  Brief  : Shared types, constants and parity helper for the EDP
//           diagnostic read path.
//  Rev    : 1.0  initial release
// ============================================================================
package edp_diag_reader_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } edp_diag_state_t;

  // Diagnostic read function group 120..127 (octal)
  localparam logic [7:0] DIAG_FUNC_BASE = 8'o120;

  // EBUS word, KL10 bit numbering: bit 0 is the MSB
  typedef logic [0:35] ebus_word_t;

  // Odd parity: returns the bit that makes the total count of ones odd
  function automatic logic odd_parity(input ebus_word_t w);
    return ~(^w);
  endfunction

endpackage : edp_diag_reader_pkg
`default_nettype wire

// File: rtl/edp_diag_reader_snapbuf.sv
`default_nettype none
// ============================================================================
//  Module : edp_diag_snapbuf
//  Brief  : 8 x 36 snapshot register file, one write port, one
//           combinational read port, synchronous clear.
//  Rev    : 1.0  initial release
// ============================================================================
module edp_diag_snapbuf
  import edp_diag_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [2:0] i_wr_idx,
  input  ebus_word_t i_wr_data,
  input  logic [2:0] i_rd_idx,
  output ebus_word_t o_rd_data
);

  ebus_word_t mem_q [8];
  ebus_word_t mem_d [8];

  // Next contents: write the addressed entry, hold the rest
  always_comb begin
    mem_d = mem_q;
    if (i_we) begin
      mem_d[i_wr_idx] = i_wr_data;
    end
  end

  // Storage with synchronous clear of every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign o_rd_data = mem_q[i_rd_idx];

endmodule : edp_diag_snapbuf
`default_nettype wire

// File: rtl/edp_diag_reader.sv
`default_nettype none
// ============================================================================
//  Module : edp_diag_reader
//  Brief  : Diagnostic read sequencer for the EBOX data path. Selects read
//           functions 120-127, waits a settle time, captures EBUS; single
//           reads or an eight-function sweep into a snapshot buffer.
//  Rev    : 1.0  initial release
// ============================================================================
module edp_diag_reader
  import edp_diag_reader_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk_h,
  input  logic       crobar_h,
  input  logic       req_h,
  input  logic       sweep_h,
  input  logic [2:0] func_h,
  output logic       busy_h,
  output logic       done_h,
  output ebus_word_t rd_data_h,
  output logic       rd_par_h,
  input  logic [2:0] snap_idx_h,
  output ebus_word_t snap_data_h,
  output logic       diag_read_func_12x_h,
  output logic       diag_04_a_h,
  output logic       diag_05_a_h,
  output logic       diag_06_a_h,
  input  ebus_word_t ebus_d_h
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  edp_diag_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      func_q, func_d;
  logic            sweep_q, sweep_d;
  ebus_word_t      rd_data_q, rd_data_d;
  logic            rd_par_q, rd_par_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            f12x_q, f12x_d;
  logic [2:0]      sel_q, sel_d;
  logic            snap_we;

  // State and datapath registers; crobar clears everything including outputs
  always_ff @(posedge clk_h) begin
    if (crobar_h) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      func_q    <= '0;
      sweep_q   <= 1'b0;
      rd_data_q <= '0;
      rd_par_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      f12x_q    <= 1'b0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func_q    <= func_d;
      sweep_q   <= sweep_d;
      rd_data_q <= rd_data_d;
      rd_par_q  <= rd_par_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      f12x_q    <= f12x_d;
      sel_q     <= sel_d;
    end
  end

  // Next-state, counters, function number and capture path
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func_d    = func_q;
    sweep_d   = sweep_q;
    rd_data_d = rd_data_q;
    rd_par_d  = rd_par_q;
    snap_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_h) begin
          sweep_d = sweep_h;
          func_d  = sweep_h ? 3'd0 : func_h;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        cnt_d   = SETTLE_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CAPTURE: begin
        rd_data_d = ebus_d_h;
        rd_par_d  = odd_parity(ebus_d_h);
        snap_we   = sweep_q;
        if (!sweep_q || (func_q == 3'd7)) begin
          state_d = ST_DONE;
        end else begin
          func_d = func_q + 3'd1;
          if (HOLD_CYCLES > 0) begin
            cnt_d   = HOLD_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_SELECT;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SELECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the next state so they line up with it;
  // select lines update on entry to SELECT and otherwise hold
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    f12x_d = (state_d == ST_SELECT) || (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
    sel_d  = (state_d == ST_SELECT) ? func_d : sel_q;
  end

  edp_diag_snapbuf u_snapbuf (
    .clk       (clk_h),
    .rst       (crobar_h),
    .i_we      (snap_we),
    .i_wr_idx  (func_q),
    .i_wr_data (ebus_d_h),
    .i_rd_idx  (snap_idx_h),
    .o_rd_data (snap_data_h)
  );

  assign busy_h               = busy_q;
  assign done_h               = done_q;
  assign rd_data_h            = rd_data_q;
  assign rd_par_h             = rd_par_q;
  assign diag_read_func_12x_h = f12x_q;
  assign diag_04_a_h          = sel_q[2];
  assign diag_05_a_h          = sel_q[1];
  assign diag_06_a_h          = sel_q[0];

endmodule : edp_diag_reader
`default_nettype wire

// File: tb/tb_edp_diag_reader.sv
`default_nettype none
// ============================================================================
//  Module : tb_edp_diag_reader
//  Brief  : Directed self-checking bench for edp_diag_reader.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_edp_diag_reader;

  localparam logic [35:0] SW_BASE = 36'o100000000000;

  logic clk_h = 1'b0;
  always #10 clk_h = ~clk_h;

  logic        crobar_h, req_h, sweep_h;
  logic [2:0]  func_h, snap_idx_h;
  logic        busy_h, done_h, rd_par_h, f12x, d04, d05, d06;
  logic [35:0] rd_data_h, snap_data_h, ebus_d_h, ebus_drv;
  logic        ebus_track;

  // In tracking mode EBUS answers with base + currently selected function
  assign ebus_d_h = ebus_track ? (SW_BASE + {33'd0, d04, d05, d06}) : ebus_drv;

  logic        req2, busy2, done2, par2, f12x2, e04, e05, e06;
  logic [35:0] rd2, snap2, ebus2;
  logic [2:0]  zero3 = 3'd0;
  logic [2:0]  one3  = 3'd1;
  logic        zero1 = 1'b0;

  edp_diag_reader u_dut (
    .clk_h(clk_h), .crobar_h(crobar_h), .req_h(req_h), .sweep_h(sweep_h),
    .func_h(func_h), .busy_h(busy_h), .done_h(done_h), .rd_data_h(rd_data_h),
    .rd_par_h(rd_par_h), .snap_idx_h(snap_idx_h), .snap_data_h(snap_data_h),
    .diag_read_func_12x_h(f12x), .diag_04_a_h(d04), .diag_05_a_h(d05),
    .diag_06_a_h(d06), .ebus_d_h(ebus_d_h)
  );

  edp_diag_reader #(.SETTLE_CYCLES(1), .HOLD_CYCLES(1)) u_dut_s1 (
    .clk_h(clk_h), .crobar_h(crobar_h), .req_h(req2), .sweep_h(zero1),
    .func_h(one3), .busy_h(busy2), .done_h(done2), .rd_data_h(rd2),
    .rd_par_h(par2), .snap_idx_h(zero3), .snap_data_h(snap2),
    .diag_read_func_12x_h(f12x2), .diag_04_a_h(e04), .diag_05_a_h(e05),
    .diag_06_a_h(e06), .ebus_d_h(ebus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
    end
  endtask

  // Walk all eight snapshot entries; expected = base, or base+index
  task automatic chk_snap(input string tag, input logic [35:0] base, input bit add_idx);
    for (int i = 0; i < 8; i++) begin
      snap_idx_h = 3'(i);
      #1;
      chk(tag, snap_data_h, add_idx ? (base + 36'(i)) : base);
    end
  endtask

  int done_cyc, lows, falls, ndone;
  logic prev_f;
  logic [35:0] cap;

  initial begin
    crobar_h = 1'b1; req_h = 1'b0; sweep_h = 1'b0; func_h = '0; snap_idx_h = '0;
    ebus_drv = '0; ebus_track = 1'b0; req2 = 1'b0; ebus2 = 36'o777000000000;

    // ---------------- reset ----------------
    tick(); tick();
    crobar_h = 1'b0;
    chk("rst_busy", busy_h, 0);
    chk("rst_done", done_h, 0);
    chk("rst_f12x", f12x, 0);
    chk("rst_sel", {d04, d05, d06}, 0);
    chk("rst_data", rd_data_h, 0);
    chk("rst_par", rd_par_h, 1);
    chk("rst_par_s1", par2, 1);
    chk_snap("rst_snap", 36'd0, 0);

    // ---------------- single read func 3 ----------------
    tick();
    func_h = 3'd3; ebus_drv = 36'o123456701234; req_h = 1'b1;
    tick();                                   // cycle 1: SELECT
    req_h = 1'b0;
    chk("single_f12x_c1", f12x, 1);
    chk("single_sel_c1", {d04, d05, d06}, 3'b011);
    chk("single_busy_c1", busy_h, 1);
    tick(); tick(); tick();                   // cycle 4: CAPTURE
    chk("single_done_c4", done_h, 0);
    tick();                                   // cycle 5: DONE
    chk("single_done_c5", done_h, 1);
    chk("single_data", rd_data_h, 36'o123456701234);
    chk("single_par", rd_par_h, 0);
    chk("single_f12x_done", f12x, 0);
    tick();
    chk("single_busy_after", busy_h, 0);
    chk("single_done_after", done_h, 0);
    chk_snap("single_snap_untouched", 36'd0, 0);

    // ---------------- sweep ----------------
    ebus_track = 1'b1; sweep_h = 1'b1; req_h = 1'b1;
    tick();
    req_h = 1'b0; sweep_h = 1'b0;
    done_cyc = 0; lows = 0; falls = 0; prev_f = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) tick();
      if (done_h) begin
        done_cyc = c;
        break;
      end
      if (!f12x) lows++;
      if (prev_f && !f12x) falls++;
      prev_f = f12x;
    end
    chk("sweep_done_cycle", 36'(done_cyc), 36'd40);
    chk("sweep_f12x_low_cycles", 36'(lows), 36'd7);
    chk("sweep_f12x_low_runs", 36'(falls), 36'd7);
    chk("sweep_last_data", rd_data_h, SW_BASE + 36'd7);
    chk("sweep_last_par", rd_par_h, 1);
    tick();
    chk("sweep_busy_after", busy_h, 0);
    chk_snap("sweep_snap", SW_BASE, 1);

    // ---------------- settle boundary, SETTLE_CYCLES=1 ----------------
    req2 = 1'b1;
    tick();                                   // cycle 1: SELECT
    req2 = 1'b0;
    ebus2 = 36'o000111222333;
    chk("s1_f12x_c1", f12x2, 1);
    chk("s1_sel_c1", {e04, e05, e06}, 3'b001);
    tick(); tick();                           // cycle 3: CAPTURE
    chk("s1_done_c3", done2, 0);
    tick();                                   // cycle 4: DONE
    chk("s1_done_c4", done2, 1);
    chk("s1_data_c4", rd2, 36'o000111222333);
    ebus2 = 36'o555555555555;
    tick();
    chk("s1_data_hold", rd2, 36'o000111222333);
    chk("s1_busy_after", busy2, 0);

    // ---------------- busy ignore ----------------
    func_h = 3'd2; req_h = 1'b1;
    tick();                                   // cycle 1
    req_h = 1'b0; ndone = 0; cap = '0;
    tick();                                   // cycle 2: busy, try again
    func_h = 3'd5; req_h = 1'b1;
    tick();
    req_h = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (done_h) begin
        ndone++;
        cap = rd_data_h;
      end
      tick();
    end
    chk("busy_ign_done_count", 36'(ndone), 36'd1);
    chk("busy_ign_data", cap, SW_BASE + 36'd2);
    chk("busy_ign_sel_hold", {d04, d05, d06}, 3'b010);

    // ---------------- abort during sweep step 4 ----------------
    sweep_h = 1'b1; req_h = 1'b1;
    tick();                                   // cycle 1
    req_h = 1'b0; sweep_h = 1'b0;
    for (int c = 1; c < 22; c++) tick();      // cycle 22: step 4 SETTLE
    chk("abort_sel_step4", {d04, d05, d06}, 3'd4);
    snap_idx_h = 3'd3; #1;
    chk("abort_pre_snap3", snap_data_h, SW_BASE + 36'd3);
    crobar_h = 1'b1;
    tick();
    crobar_h = 1'b0;
    chk("abort_busy", busy_h, 0);
    chk("abort_f12x", f12x, 0);
    chk("abort_done", done_h, 0);
    chk("abort_data", rd_data_h, 0);
    chk("abort_par", rd_par_h, 1);
    chk_snap("abort_snap", 36'd0, 0);
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (done_h) ndone++;
    end
    chk("abort_no_done", 36'(ndone), 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_edp_diag_reader
`default_nettype wire
